// File: rtl/pitch_tracker.sv
// pitch_tracker
//   Measures the fundamental period of a signed audio sample stream using
//   Schmitt-triggered rising zero crossings, then converts the period P into
//   the oscillator phase increment floor(2^PHASE_BITS / P) with a bit-serial
//   restoring divider. A long stretch without crossings is treated as silence
//   and drops the lock.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous active-low reset (release synchronised inside)
//   sample_in        two's-complement audio sample
//   sample_valid_in  one-cycle strobe, sample_in is consumed only when high
//   phase_acc_out    phase increment for the oscillator, 0 means silence
//   phase_valid_out  one-cycle pulse when phase_acc_out takes a new value
//   locked_out       high while a valid pitch is being tracked
module pitch_tracker #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int HYST         = 64,
  parameter int MIN_PERIOD   = 8,
  parameter int MAX_PERIOD   = 2047,
  parameter int PHASE_BITS   = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [PHASE_BITS-1:0]   phase_acc_out,
  output logic                    phase_valid_out,
  output logic                    locked_out
);

  // Period counter wide enough to hold MAX_PERIOD itself.
  localparam int CNT_W     = $clog2(MAX_PERIOD + 1);
  // The dividend 2^PHASE_BITS has PHASE_BITS+1 bits, one quotient bit per step.
  localparam int DIV_STEPS = PHASE_BITS + 1;
  localparam int STEP_W    = $clog2(DIV_STEPS);

  localparam logic signed [SAMPLE_WIDTH-1:0] HYST_POS = SAMPLE_WIDTH'(HYST);
  localparam logic signed [SAMPLE_WIDTH-1:0] HYST_NEG = SAMPLE_WIDTH'(-HYST);

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX_M1 = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_MIN    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W:0]    CNT_LIMIT  = (CNT_W + 1)'(MAX_PERIOD);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(DIV_STEPS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Reset synchroniser
  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  // Crossing detector state
  logic             armed_q,    armed_d;
  logic             ref_seen_q, ref_seen_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Divider state; start_q is the one-cycle latch stage ahead of DIVIDE
  logic [1:0]            state_q, state_d;
  logic                  start_q, start_d;
  logic [CNT_W-1:0]      p_q,     p_d;
  logic [CNT_W:0]        rem_q,   rem_d;
  logic [PHASE_BITS-1:0] quo_q,   quo_d;
  logic [STEP_W-1:0]     step_q,  step_d;

  // Output registers
  logic [PHASE_BITS-1:0] phase_q,  phase_d;
  logic                  pvalid_q, pvalid_d;
  logic                  locked_q, locked_d;

  // Decode
  logic                  above_s;
  logic                  below_s;
  logic                  cross_s;
  logic [CNT_W:0]        cnt_inc_s;
  logic [CNT_W-1:0]      period_s;
  logic                  timeout_s;
  logic                  busy_s;
  logic                  accept_s;
  logic                  first_step_s;
  logic [CNT_W:0]        p_ext_s;
  logic [CNT_W:0]        rem_shift_s;
  logic                  ge_s;
  logic [CNT_W:0]        rem_next_s;
  logic [PHASE_BITS-1:0] quo_next_s;

  // Reset synchroniser: assertion propagates at once, release waits two edges.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Schmitt trigger, period measurement and acceptance decode.
  always_comb begin
    above_s   = ($signed(sample_in) >= HYST_POS);
    below_s   = ($signed(sample_in) <  HYST_NEG);
    cross_s   = sample_valid_in && armed_q && above_s;
    cnt_inc_s = {1'b0, cnt_q} + {1'b0, CNT_ONE};
    period_s  = cnt_q + CNT_ONE;
    // A crossing always wins over a timeout on the same sample.
    timeout_s = sample_valid_in && !cross_s && (cnt_inc_s >= CNT_LIMIT);
    // The latch cycle and the DONE cycle both count as busy.
    busy_s    = start_q || (state_q != ST_IDLE);
    accept_s  = cross_s && ref_seen_q && (period_s >= CNT_MIN) && !busy_s;
  end

  // Detector next state; nothing moves on cycles without a valid sample.
  always_comb begin
    armed_d    = armed_q;
    ref_seen_d = ref_seen_q;
    cnt_d      = cnt_q;
    if (timeout_s) begin
      // Silence: forget the reference crossing and park the counter.
      armed_d    = 1'b0;
      ref_seen_d = 1'b0;
      cnt_d      = CNT_MAX_M1;
    end else if (cross_s) begin
      // The first crossing after silence only becomes the reference.
      armed_d    = 1'b0;
      ref_seen_d = 1'b1;
      cnt_d      = {CNT_W{1'b0}};
    end else if (sample_valid_in) begin
      cnt_d = cnt_q + CNT_ONE;
      if (below_s) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // One restoring-division step. The dividend is a single 1 followed by
  // zeros, so only the first step shifts in a 1.
  always_comb begin
    first_step_s = (step_q == {STEP_W{1'b0}});
    p_ext_s      = {1'b0, p_q};
    rem_shift_s  = (rem_q << 1'b1) | {{CNT_W{1'b0}}, first_step_s};
    ge_s         = (rem_shift_s >= p_ext_s);
    if (ge_s) begin
      rem_next_s = rem_shift_s - p_ext_s;
    end else begin
      rem_next_s = rem_shift_s;
    end
    // The quotient MSB (weight 2^PHASE_BITS) is always 0 because P >= 2,
    // so it is allowed to fall off the top of the shift register.
    quo_next_s = (quo_q << 1'b1) | {{(PHASE_BITS-1){1'b0}}, ge_s};
  end

  // Divider FSM and output update; a timeout aborts any division in flight.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    p_d      = p_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    phase_d  = phase_q;
    pvalid_d = 1'b0;
    locked_d = locked_q;
    if (timeout_s) begin
      state_d  = ST_IDLE;
      start_d  = 1'b0;
      phase_d  = {PHASE_BITS{1'b0}};
      locked_d = 1'b0;
      // Pulse only on the falling edge of lock.
      pvalid_d = locked_q;
    end else begin
      if (accept_s) begin
        start_d = 1'b1;
        p_d     = period_s;
      end else begin
        start_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            state_d = ST_DIVIDE;
            rem_d   = {(CNT_W+1){1'b0}};
            quo_d   = {PHASE_BITS{1'b0}};
            step_d  = {STEP_W{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DIVIDE: begin
          rem_d  = rem_next_s;
          quo_d  = quo_next_s;
          step_d = step_q + STEP_ONE;
          if (step_q == STEP_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIVIDE;
          end
        end
        ST_DONE: begin
          phase_d  = quo_q;
          pvalid_d = 1'b1;
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      armed_q    <= 1'b0;
      ref_seen_q <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      p_q        <= {CNT_W{1'b0}};
      rem_q      <= {(CNT_W+1){1'b0}};
      quo_q      <= {PHASE_BITS{1'b0}};
      step_q     <= {STEP_W{1'b0}};
      phase_q    <= {PHASE_BITS{1'b0}};
      pvalid_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      ref_seen_q <= ref_seen_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      start_q    <= start_d;
      p_q        <= p_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      pvalid_q   <= pvalid_d;
      locked_q   <= locked_d;
    end
  end

  assign phase_acc_out   = phase_q;
  assign phase_valid_out = pvalid_q;
  assign locked_out      = locked_q;

endmodule

// File: tb/tb_pitch_tracker.sv
module tb_pitch_tracker;
  localparam int SW   = 16;
  localparam int HYST = 64;
  localparam int MINP = 8;
  localparam int MAXP = 2047;
  localparam int PB   = 24;
  localparam int LAT  = 27;
  localparam int INF  = 2147483647;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic [PB-1:0] phase_acc_out;
  logic          phase_valid_out;
  logic          locked_out;

  pitch_tracker #(
    .SAMPLE_WIDTH(SW), .HYST(HYST), .MIN_PERIOD(MINP),
    .MAX_PERIOD(MAXP), .PHASE_BITS(PB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .phase_acc_out(phase_acc_out),
    .phase_valid_out(phase_valid_out), .locked_out(locked_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int val; int due; bit lk; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: spec-level rules on plain integers, edges as time.
  bit m_armed;
  bit m_ref;
  int m_cnt;
  int busy_until;
  int locked_from;
  int unlock_at;
  int n_accept = 0;
  int last_phase = 0;

  task automatic chk(string name, longint act, longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: cycle %0d actual %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_ref = 0; m_cnt = 0; busy_until = 0;
    locked_from = INF; unlock_at = INF;
    exp_q.delete();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  // Apply one cycle of input; model predicts effects of the coming edge e.
  task automatic drive(bit v, int s);
    int e;
    int p;
    exp_t x;
    e = cyc + 1;
    if (rst_in && v) begin
      if (m_armed && s >= HYST) begin
        p = m_cnt + 1;
        m_cnt = 0;
        m_armed = 0;
        if (!m_ref) m_ref = 1;
        else if (p >= MINP && e > busy_until) begin
          x.val = (1 << PB) / p;
          x.due = e + LAT;
          x.lk  = 1;
          exp_q.push_back(x);
          busy_until = x.due;
          n_accept++;
          if (!(locked_from != INF && unlock_at == INF)) begin
            locked_from = x.due;
            unlock_at = INF;
          end
        end
      end else begin
        if (s < -HYST) m_armed = 1;
        if (m_cnt + 1 >= MAXP) begin
          m_cnt = MAXP - 1;
          m_armed = 0;
          m_ref = 0;
          if (busy_until >= e) begin
            if (exp_q.size() > 0 && exp_q[$].due >= e) begin
              x = exp_q.pop_back();
              if (locked_from == x.due) locked_from = INF;
            end
            busy_until = 0;
          end
          if (locked_from < e && unlock_at == INF) begin
            x.val = 0; x.due = e; x.lk = 0;
            exp_q.push_back(x);
            unlock_at = e;
          end
        end else begin
          m_cnt++;
        end
      end
    end
    sample_in = s[SW-1:0];
    sample_valid_in = v;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, rnd_sample());
  endtask

  task automatic square(int period, int nper, int maxgap, int amp);
    int lo;
    int g;
    lo = period - period / 2;
    for (int i = 0; i < period * nper; i++) begin
      g = int'($urandom_range(maxgap, 0));
      idle(g);
      drive(1'b1, ((i % period) < lo) ? -amp : amp);
    end
  endtask

  // Monitor: pops expectations on output pulses, checks lock and hold state.
  always @(negedge clk_in) begin : mon
    exp_t x;
    bit exp_lk;
    if (!rst_in) begin
      last_phase = 0;
      chk("reset_phase", phase_acc_out, 0);
      chk("reset_valid", phase_valid_out, 0);
      chk("reset_locked", locked_out, 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        x = exp_q.pop_front();
        chk("missed_pulse_cycle", cyc, x.due);
      end
      if (phase_valid_out) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", phase_valid_out, 0);
        else begin
          x = exp_q.pop_front();
          chk("pulse_value", phase_acc_out, x.val);
          chk("pulse_cycle", cyc, x.due);
          chk("pulse_locked", locked_out, x.lk);
          last_phase = x.val;
        end
      end else begin
        chk("phase_hold", phase_acc_out, last_phase);
      end
      exp_lk = (locked_from <= cyc) && (cyc < unlock_at);
      chk("locked", locked_out, exp_lk);
    end
  end

  initial begin
    int start;
    model_reset();
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    // Reset with random inputs
    repeat (6) drive(1'($urandom_range(1, 0)), rnd_sample());
    rst_in = 1'b1;
    idle(4);

    // Lock at period 28, then change to 27
    square(28, 3, 0, 1000);
    square(27, 3, 0, 1000);
    // Random gaps between valid samples
    square(28, 3, 3, 1000);

    // Divider busy: crossings every 8 cycles
    square(8, 12, 0, 1000);

    // Triangle inside the hysteresis band: no crossings
    for (int k = 0; k < 60; k++) drive(1'b1, -50 + 5 * (k % 21));
    // Crossings every 4 samples: below MIN_PERIOD
    square(4, 20, 0, 1000);

    // Random periods and amplitudes
    for (int r = 0; r < 6; r++)
      square(int'($urandom_range(60, MINP)), 4, int'($urandom_range(2, 0)),
             int'($urandom_range(30000, HYST + 1)));
    // Random noise
    for (int k = 0; k < 300; k++) drive(1'($urandom_range(1, 0)), rnd_sample());

    // Timeout: lock, then silence, then relock
    square(28, 3, 0, 1000);
    repeat (2100) drive(1'b1, 0);
    square(28, 3, 0, 1000);

    // Reset mid-divide
    start = n_accept;
    for (int i = 0; i < 200 && n_accept == start; i++)
      drive(1'b1, ((i % 28) < 14) ? -1000 : 1000);
    idle(11);
    rst_in = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_phase", phase_acc_out, 0);
    chk("mid_reset_valid", phase_valid_out, 0);
    chk("mid_reset_locked", locked_out, 0);
    @(posedge clk_in);
    #1;
    repeat (2) drive(1'($urandom_range(1, 0)), rnd_sample());
    rst_in = 1'b1;
    idle(44);
    square(28, 3, 1, 1000);

    // Drain
    repeat (40) drive(1'b0, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
